// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
//
// Generates a short burst of pseudo-random bytes with an 8-bit Fibonacci LFSR.
// It reads the seed and the tap mask from a shared register file, then writes
// N output bytes back into that register file.
//
// Register-file map (5-bit address space):
//   16        seed (a value of 0x00 is replaced by 0x01)
//   17        tap mask (0x00 is legal: zeros are shifted in)
//   18+k      output byte k, for k = 0..N-1
//
// Ports:
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  asynchronous reset, active low
//   start    in   1  run request, only looked at in IDLE
//   len      in   5  byte count, latched when start is accepted (clamped to 1..14)
//   rd_data  in   8  register-file read data, combinational from r_addr
//   busy     out  1  block owns the register file (router select)
//   done     out  1  one-cycle completion pulse
//   r_addr   out  5  read address (16/17 while loading, else 0)
//   w_addr   out  5  write address (18+idx in WRITE, else 0)
//   din      out  8  write data (LFSR state in WRITE, else 0)
//   wr_en    out  1  write enable (WRITE only)
//
// Timing: the run is busy for 2+9N cycles (seed load, tap load, then 8 shifts
// plus 1 write per byte), and done pulses in the following cycle.

module lfsr_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] len,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic [4:0] r_addr,
  output logic [4:0] w_addr,
  output logic [7:0] din,
  output logic       wr_en
);

  localparam logic [4:0] SEED_ADDR = 5'd16;
  localparam logic [4:0] TAP_ADDR  = 5'd17;
  localparam logic [4:0] OUT_BASE  = 5'd18;
  localparam logic [3:0] MAX_BYTES = 4'd14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_SEED = 3'd1,
    LD_TAP  = 3'd2,
    STEP    = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] tap_q, tap_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] n_q, n_d;

  // Clamp the requested length to 1..14 so that the last write lands at 31.
  function automatic logic [3:0] clamp_len(input logic [4:0] l);
    logic [3:0] r;
    if (l == 5'd0)
      r = 4'd1;
    else if (l > {1'b0, MAX_BYTES})
      r = MAX_BYTES;
    else
      r = l[3:0];
    return r;
  endfunction

  // An all-zero seed would lock most tap masks at zero, so it becomes 0x01.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= 8'h00;
      tap_q     <= 8'h00;
      bit_cnt_q <= 3'd0;
      idx_q     <= 4'd0;
      n_q       <= 4'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      tap_q     <= tap_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    tap_d     = tap_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    n_d       = n_q;

    busy      = 1'b0;
    done      = 1'b0;
    r_addr    = 5'd0;
    w_addr    = 5'd0;
    din       = 8'h00;
    wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = clamp_len(len);
          state_d = LD_SEED;
        end
      end

      LD_SEED: begin
        busy    = 1'b1;
        r_addr  = SEED_ADDR;
        lfsr_d  = fix_seed(rd_data);
        state_d = LD_TAP;
      end

      LD_TAP: begin
        busy      = 1'b1;
        r_addr    = TAP_ADDR;
        tap_d     = rd_data;
        bit_cnt_d = 3'd0;
        idx_d     = 4'd0;
        state_d   = STEP;
      end

      STEP: begin
        busy      = 1'b1;
        lfsr_d    = {lfsr_q[6:0], ^(lfsr_q & tap_q)};
        // The 3-bit counter wraps back to 0 after the eighth shift, which makes it ready for the next byte.
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7)
          state_d = WRITE;
      end

      WRITE: begin
        busy   = 1'b1;
        wr_en  = 1'b1;
        w_addr = OUT_BASE + {1'b0, idx_q};
        din    = lfsr_q;
        if (idx_q == n_q - 4'd1) begin
          state_d = DONE;
        end else begin
          // The LFSR state carries over, so the bytes form one continuous stream.
          idx_d   = idx_q + 4'd1;
          state_d = STEP;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Testbench for lfsr_seq_ctrl. It models the register file, keeps a queue of
// expected writes, and uses a monitor that checks each write as it appears.
module tb_lfsr_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] len;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [4:0] r_addr;
  logic [4:0] w_addr;
  logic [7:0] din;
  logic       wr_en;

  logic [7:0] mem [32];

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  assign rd_data = mem[r_addr];

  lfsr_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .r_addr  (r_addr),
    .w_addr  (w_addr),
    .din     (din),
    .wr_en   (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Reference: eight Fibonacci shifts of an 8-bit LFSR.
  function automatic logic [7:0] ref_byte(input logic [7:0] s, input logic [7:0] t);
    logic [7:0] x;
    x = s;
    for (int i = 0; i < 8; i++) begin
      x = {x[6:0], ^(x & t)};
    end
    return x;
  endfunction

  // Monitor: check each write against the queue, and the quiet output values between writes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(w_addr), 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", int'(w_addr), int'(e.a));
          chk("write_data", int'(din), int'(e.d));
        end
        mem[w_addr] = din;
      end else begin
        chk("idle_waddr_din", int'({w_addr, din}), 0);
      end
    end
  end

  // glitch_at >= 0: pulse start, with a different len, at that busy cycle.
  // rst_at >= 0: pull rst_n low at that busy cycle, then return.
  task automatic run(input logic [7:0] seed, input logic [7:0] tap, input logic [4:0] l,
                     input int exp_busy, input int glitch_at, input int rst_at, input string tag);
    int cnt;
    mem[16] = seed;
    mem[17] = tap;
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 5'd3;
    cnt   = 0;
    while (busy && cnt < 400) begin
      if (cnt == glitch_at) begin
        start = 1'b1;
        len   = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (cnt == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"},   int'(busy),   0);
        chk({tag, "_rst_done"},   int'(done),   0);
        chk({tag, "_rst_wr_en"},  int'(wr_en),  0);
        chk({tag, "_rst_r_addr"}, int'(r_addr), 0);
        chk({tag, "_rst_w_addr"}, int'(w_addr), 0);
        chk({tag, "_rst_din"},    int'(din),    0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, cnt, exp_busy);
    chk({tag, "_done_pulse"}, int'(done), 1);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] s;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    len   = 5'd0;
    #12;
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    chk("reset_wr_en",  int'(wr_en),  0);
    chk("reset_r_addr", int'(r_addr), 0);
    chk("reset_w_addr", int'(w_addr), 0);
    chk("reset_din",    int'(din),    0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // seed 0x01, tap 0xB8, one byte: 0x1C
    push(5'd18, 8'h1C);
    run(8'h01, 8'hB8, 5'd1, 11, -1, -1, "basic");

    // zero seed is substituted with 0x01
    push(5'd18, 8'h1C);
    run(8'h00, 8'hB8, 5'd1, 11, -1, -1, "zero_seed");

    // zero tap shifts in zeros
    push(5'd18, 8'h00);
    push(5'd19, 8'h00);
    run(8'hFF, 8'h00, 5'd2, 20, -1, -1, "zero_tap");

    // len 0 clamps to one byte
    push(5'd18, 8'h1C);
    run(8'h01, 8'hB8, 5'd0, 11, -1, -1, "len0");

    // len 20 clamps to 14 bytes at 18..31
    s = 8'hA5;
    for (int k = 0; k < 14; k++) begin
      s = ref_byte(s, 8'hB8);
      push(5'(18 + k), s);
    end
    run(8'hA5, 8'hB8, 5'd20, 128, -1, -1, "len20");

    // start pulsed mid-STEP is ignored
    push(5'd18, 8'h1C);
    run(8'h01, 8'hB8, 5'd1, 11, 5, -1, "glitch");

    // reset during byte 1 STEP: only the write at 18 happens
    push(5'd18, 8'h1C);
    run(8'h01, 8'hB8, 5'd2, 0, -1, 13, "midreset");
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i % 10 == 9) chk("post_reset_busy", int'(busy), 0);
    end
    chk("post_reset_pending", exp_q.size(), 0);

    // block accepts a fresh run after the reset
    push(5'd18, 8'h1C);
    run(8'h01, 8'hB8, 5'd1, 11, -1, -1, "recover");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  run request, sampled in IDLE only.
REQ-004 SHALL have ports: len  in  5  output byte count, latched on accepted start.
REQ-005 SHALL have ports: rd_data  in  8  register-file read data, combinational from r_addr, valid in the same cycle.
REQ-006 SHALL have ports: busy  out  1  high while the block owns the register file; drives the router select.
REQ-007 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: r_addr  out  5  internal read address.
REQ-009 SHALL have ports: w_addr  out  5  internal write address.
REQ-010 SHALL have ports: din  out  8  internal write data.
REQ-011 SHALL have ports: wr_en  out  1  internal write enable.

Function
REQ-012 SHALL use the register-file map: seed at address 16, tap mask at address 17, output bytes k=0..N-1 at address 18+k.
REQ-013 SHALL implement FSM states IDLE, LD_SEED, LD_TAP, STEP, WRITE and DONE.
REQ-014 IDLE SHALL move to LD_SEED on the rising edge where start=1, latching N = clamp(len), with 0->1 and >14->14.
REQ-015 LD_SEED SHALL drive r_addr=16 and latch rd_data into the 8-bit state register; a latched value of 0x00 SHALL be replaced by 0x01.
REQ-016 LD_TAP SHALL drive r_addr=17, latch rd_data as the tap mask, clear the bit counter and byte index, then go to STEP.
REQ-017 STEP SHALL perform one Fibonacci shift per cycle: fb = XOR-reduce(state & tap); state <= {state[6:0], fb}.
REQ-018 STEP SHALL remain in STEP for exactly 8 cycles (bit counter 0..7), then go to WRITE.
REQ-019 WRITE SHALL, for one cycle, drive wr_en=1, w_addr=18+idx and din=state, where state is the value after the 8 shifts.
REQ-020 WRITE SHALL go to DONE if idx==N-1; otherwise it SHALL increment idx and return to STEP; state SHALL carry over between bytes, not be reloaded.
REQ-021 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-022 busy SHALL be 1 exactly in LD_SEED, LD_TAP, STEP and WRITE.
REQ-023 busy SHALL rise the cycle after start is accepted and fall on entry to DONE.
REQ-024 Total latency SHALL be 2+9N busy cycles, with done in the following cycle.
REQ-025 start asserted while not in IDLE (busy or DONE) SHALL be ignored; it SHALL be neither queued nor able to alter len/N.
REQ-026 Outside LD_SEED and LD_TAP, r_addr SHALL be 0; outside WRITE, w_addr, din and wr_en SHALL be 0.
REQ-027 A tap mask of 0x00 SHALL be legal: zeros are shifted in.
REQ-028 The write address SHALL never exceed 31.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE; busy=0, done=0, wr_en=0, r_addr=0, w_addr=0, din=0; state, tap, counters and N cleared.
REQ-030 Reset mid-run SHALL abort with no further writes; after release the block SHALL wait for a new start.

Verification
REQ-031 Seed 0x01, tap 0xB8, len=1, start -> busy high 11 cycles; one write of 0x1C at address 18; done pulses once.
REQ-032 Seed 0x00, tap 0xB8, len=1 -> seed substituted to 0x01; writes 0x1C at address 18.
REQ-033 Seed 0xFF, tap 0x00, len=2 -> writes 0x00 at 18 and 0x00 at 19; busy 20 cycles.
REQ-034 len=0 -> one write at 18; len=20 -> 14 writes at 18..31; no write outside 18..31.
REQ-035 start pulsed mid-STEP -> ignored, output unchanged; rst_n low during a STEP cycle of byte 1 -> outputs zero at once, no write at 19, IDLE after release.
